// File: rtl/pc_branch_unit.sv
// Fetch-stage program counter with branch/jump redirect, stall handling,
// a one-cycle IF/ID flush and a sticky trap for misaligned redirect targets.
module pc_branch_unit #(
  parameter int unsigned            WIDTH    = 16,
  parameter logic [WIDTH-1:0]       RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_offset_sl1,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus2,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign_err
);

  localparam logic [WIDTH-1:0] Two = WIDTH'(2);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StRedirect,
    StHalt
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             redir_req;
  logic [WIDTH-1:0] redir_target;

  // The branch is older than the jump, so it wins a same-cycle conflict.
  always_comb begin
    redir_req    = 1'b0;
    redir_target = '0;
    if (br_valid && br_taken) begin
      redir_req    = 1'b1;
      redir_target = br_pc + Two + br_offset_sl1;
    end else if (jmp_valid) begin
      redir_req    = 1'b1;
      redir_target = jmp_target;
    end
  end

  assign pc_out   = pc_q;
  assign pc_plus2 = pc_q + Two;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      state_q      <= StBoot;
      fetch_valid  <= 1'b0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state_q)
        StBoot: begin
          state_q     <= StRun;
          fetch_valid <= 1'b1;
          flush       <= 1'b0;
        end
        StRun: begin
          if (redir_req && redir_target[0]) begin
            state_q      <= StHalt;
            misalign_err <= 1'b1;
            fetch_valid  <= 1'b0;
            flush        <= 1'b0;
          end else if (redir_req) begin
            // A redirect beats a stall.
            pc_q        <= redir_target;
            state_q     <= StRedirect;
            fetch_valid <= 1'b0;
            flush       <= 1'b1;
          end else if (!stall) begin
            pc_q <= pc_q + Two;
          end
        end
        StRedirect: begin
          state_q     <= StRun;
          fetch_valid <= 1'b1;
          flush       <= 1'b0;
        end
        StHalt: begin
          fetch_valid <= 1'b0;
          flush       <= 1'b0;
        end
        default: begin
          state_q     <= StBoot;
          fetch_valid <= 1'b0;
          flush       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios followed by random traffic, all
// compared each cycle against a behavioural model of the fetch PC.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, br_valid, br_taken, jmp_valid;
  logic [15:0] br_pc, br_offset_sl1, jmp_target;
  logic [15:0] pc_out, pc_plus2;
  logic        fetch_valid, flush, misalign_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: what the fetch unit is doing, as plain flags.
  int m_pc    = 0;
  bit m_boot  = 1'b1;
  bit m_fetch = 1'b0;
  bit m_flush = 1'b0;
  bit m_halt  = 1'b0;
  bit m_err   = 1'b0;

  pc_branch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_pc        (br_pc),
    .br_offset_sl1(br_offset_sl1),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .pc_out       (pc_out),
    .pc_plus2     (pc_plus2),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    int  tgt;
    bit  req;
    if (rst) begin
      m_pc = 0; m_boot = 1; m_fetch = 0; m_flush = 0; m_halt = 0; m_err = 0;
    end else if (m_boot) begin
      m_boot = 0; m_fetch = 1;
    end else if (m_flush) begin
      m_flush = 0; m_fetch = 1;
    end else if (!m_halt) begin
      req = 0;
      tgt = 0;
      if (br_valid && br_taken) begin
        req = 1;
        tgt = (int'(br_pc) + 2 + int'(br_offset_sl1)) % 65536;
      end else if (jmp_valid) begin
        req = 1;
        tgt = int'(jmp_target);
      end
      if (req && (tgt % 2 == 1)) begin
        m_halt = 1; m_err = 1; m_fetch = 0;
      end else if (req) begin
        m_pc = tgt; m_flush = 1; m_fetch = 0;
      end else if (!stall) begin
        m_pc = (m_pc + 2) % 65536;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc_out", {1'b0, pc_out}, 17'(m_pc));
    chk("pc_plus2", {1'b0, pc_plus2}, 17'((m_pc + 2) % 65536));
    chk("fetch_valid", {16'b0, fetch_valid}, {16'b0, m_fetch});
    chk("flush", {16'b0, flush}, {16'b0, m_flush});
    chk("misalign_err", {16'b0, misalign_err}, {16'b0, m_err});
  endtask

  task automatic idle();
    rst = 0; stall = 0; br_valid = 0; br_taken = 0; jmp_valid = 0;
    br_pc = '0; br_offset_sl1 = '0; jmp_target = '0;
  endtask

  initial begin
    idle();
    // Reset and sequential fetch
    rst = 1;
    step();
    step();
    chk("reset_pc", {1'b0, pc_out}, 17'h0);
    rst = 0;
    step();
    step();
    step();
    step();
    chk("seq_pc6", {1'b0, pc_out}, 17'h6);

    // Taken branch with negative offset
    br_valid = 1; br_taken = 1; br_pc = 16'h0040; br_offset_sl1 = 16'hFFF8;
    step();
    chk("br_neg_target", {1'b0, pc_out}, 17'h003A);
    chk("br_neg_flush", {16'b0, flush}, 17'h1);
    idle();
    step();
    chk("br_neg_fetch", {16'b0, fetch_valid}, 17'h1);
    step();
    chk("br_neg_next", {1'b0, pc_out}, 17'h003C);

    // Stall versus redirect
    jmp_valid = 1; jmp_target = 16'h0010;
    step();
    idle();
    step();
    stall = 1;
    step();
    step();
    chk("stall_hold", {1'b0, pc_out}, 17'h0010);
    br_valid = 1; br_taken = 1; br_pc = 16'h0100; br_offset_sl1 = 16'h0004;
    step();
    chk("redir_beats_stall", {1'b0, pc_out}, 17'h0106);
    br_valid = 0; br_taken = 0;
    step();
    step();
    chk("stall_after_redir", {1'b0, pc_out}, 17'h0106);
    stall = 0;

    // Branch/jump conflict, then a not-taken branch
    br_valid = 1; br_taken = 1; br_pc = 16'h001E; br_offset_sl1 = 16'h0000;
    jmp_valid = 1; jmp_target = 16'h0800;
    step();
    chk("br_wins_jmp", {1'b0, pc_out}, 17'h0020);
    idle();
    step();
    br_valid = 1; br_taken = 0; br_pc = 16'h0300; br_offset_sl1 = 16'h0040;
    step();
    chk("not_taken", {1'b0, pc_out}, 17'h0022);
    idle();

    // Wrap-around, then misaligned jump into HALT
    jmp_valid = 1; jmp_target = 16'hFFFE;
    step();
    idle();
    step();
    step();
    chk("wrap", {1'b0, pc_out}, 17'h0000);
    jmp_valid = 1; jmp_target = 16'h0101;
    step();
    chk("misalign_set", {16'b0, misalign_err}, 17'h1);
    br_valid = 1; br_taken = 1; br_pc = 16'h0200; br_offset_sl1 = 16'h0010;
    jmp_target = 16'h0400;
    step();
    step();
    chk("halt_frozen", {1'b0, pc_out}, 17'h0000);
    idle();
    rst = 1;
    step();
    chk("halt_reset_err", {16'b0, misalign_err}, 17'h0);

    // Reset during the redirect cycle
    rst = 0;
    step();
    jmp_valid = 1; jmp_target = 16'h0200;
    step();
    idle();
    rst = 1;
    step();
    chk("rst_mid_redir_flush", {16'b0, flush}, 17'h0);
    rst = 0;
    step();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      br_valid      = ($urandom_range(0, 4) == 0);
      br_taken      = $urandom_range(0, 1) == 1;
      br_pc         = 16'($urandom) & 16'hFFFE;
      br_offset_sl1 = 16'($urandom) & 16'hFFFE;
      jmp_valid     = ($urandom_range(0, 5) == 0);
      jmp_target    = 16'($urandom);
      if ($urandom_range(0, 7) != 0) jmp_target[0] = 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Fetch-stage program counter and branch redirect unit for the 16-bit datapath.
- Sits directly downstream of the sign-extend -> shift-left-1 path: consumes the already-shifted branch offset and computes the branch target (branch PC + 2 + offset).
- Holds the registered PC, advances it by 2 per fetch, applies stalls, redirects on taken branches or jumps, and issues a one-cycle flush to the IF/ID register.
- Traps misaligned targets.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.
- WIDTH, 16, datapath width; only 16 is verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  hazard-unit hold request; PC frozen while high in RUN.
- br_valid  input  1  a branch has resolved this cycle.
- br_taken  input  1  branch outcome; ignored unless br_valid is high.
- br_pc  input  16  PC of the resolving branch instruction.
- br_offset_sl1  input  16  sign-extended offset already shifted left 1 (byte offset, even).
- jmp_valid  input  1  an unconditional jump has resolved this cycle.
- jmp_target  input  16  absolute jump target.
- pc_out  output  16  current fetch address.
- pc_plus2  output  16  combinational pc_out + 2, modulo 2^16.
- fetch_valid  output  1  pc_out is a real fetch this cycle.
- flush  output  1  squash the IF/ID contents this cycle.
- misalign_err  output  1  sticky; a redirect target had bit 0 set.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. While rst is high at a rising edge:
  - pc_out = RESET_PC, state = BOOT.
  - fetch_valid = 0, flush = 0, misalign_err = 0.
  - rst overrides every other input, including mid-redirect and HALT.
- States:
  - BOOT: fetch_valid = 0, flush = 0. Moves to RUN next edge unconditionally. The PC is not advanced, so the first fetch is RESET_PC.
  - RUN: fetch_valid = 1.
  - REDIRECT: fetch_valid = 0, flush = 1. Lasts exactly one cycle, then returns to RUN regardless of stall.
  - HALT: fetch_valid = 0, flush = 0. PC frozen. Exits only via rst.
- Redirect request in RUN, evaluated combinationally, first match wins:
  1. br_valid & br_taken: target = br_pc + 2 + br_offset_sl1, modulo 2^16, carries discarded.
  2. jmp_valid: target = jmp_target. The branch is older in the pipeline, so it wins a same-cycle conflict.
  3. Otherwise: no redirect.
- br_valid with br_taken = 0 is not a redirect; behaviour is the same as no request.
- RUN next-state at each edge, in priority order:
  1. Redirect with target[0] = 1: pc_out holds, misalign_err <= 1, state <= HALT.
  2. Redirect with even target: pc_out <= target, state <= REDIRECT, even if stall is high (a redirect beats a stall).
  3. stall = 1: pc_out holds.
  4. Otherwise: pc_out <= pc_out + 2.
- Wrap-around: 16'hFFFE + 2 = 16'h0000. There is no overflow flag.
- Latency:
  - A redirect sampled at edge N shows the new pc_out and flush = 1 during cycle N+1.
  - fetch_valid = 1 at the target address from cycle N+2.
  - pc_out advances from cycle N+3 unless stalled.
- br_valid / jmp_valid during REDIRECT, BOOT or HALT are ignored; they come from squashed instructions.
- Stall in REDIRECT is ignored. Stall in the first RUN cycle after REDIRECT holds the PC at the target.
- pc_plus2 follows pc_out combinationally in every state.

Test Plan:
- Reset and sequential fetch: rst high 2 cycles, then low, RESET_PC = 0 -> BOOT 1 cycle with fetch_valid = 0; then pc_out = 0, 2, 4, 6 on successive cycles with fetch_valid = 1; flush = 0 throughout.
- Taken branch, negative offset: br_pc = 16'h0040, br_offset_sl1 = 16'hFFF8 (-8) -> pc_out = 16'h003A with flush = 1 next cycle; fetch_valid = 1 at 16'h003A the following cycle; then 16'h003C.
- Stall versus redirect: stall held high with pc_out = 16'h0010 -> pc_out holds. Then a taken branch with br_pc = 16'h0100 and offset 16'h0004 arrives with stall still high -> pc_out = 16'h0106 and flush = 1.
- Branch/jump conflict and not-taken: same cycle br_valid = 1, br_taken = 1 (target 16'h0020) and jmp_valid = 1 with jmp_target = 16'h0800 -> pc_out = 16'h0020. Separately, br_taken = 0 with jmp_valid = 0 -> normal +2, flush = 0.
- Wrap and misalign: pc_out = 16'hFFFE -> next 16'h0000. Then jmp_target = 16'h0101 -> misalign_err = 1, HALT, pc_out frozen, fetch_valid = 0; stays there through further br/jmp requests until rst, which clears misalign_err and loads RESET_PC.
- Reset mid-redirect: assert rst during the REDIRECT cycle -> next edge pc_out = RESET_PC, flush = 0, state BOOT.
